// File: rtl/dyn_array_pkg.sv
// Shared types for the dynamic-array controller: command opcodes, FSM states
// and the registered response record.
package dyn_array_pkg;

  localparam int RSP_DATA_W = 8;
  localparam int RSP_SIZE_W = 5;

  typedef enum logic [2:0] {
    OP_NEW    = 3'd0,
    OP_DELETE = 3'd1,
    OP_SIZE   = 3'd2,
    OP_READ   = 3'd3,
    OP_WRITE  = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [RSP_DATA_W-1:0] data;
    logic [RSP_SIZE_W-1:0] size;
    logic                  err;
  } rsp_t;

endpackage

// File: rtl/dyn_array_store.sv
// Element storage for all handles: one synchronous write port and one
// combinational read port, each addressed by (handle, index).
module dyn_array_store #(
  parameter int WIDTH       = 8,
  parameter int NUM_HANDLES = 4,
  parameter int MAX_LEN     = 16,
  parameter int HW          = 2,
  parameter int LW          = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [HW-1:0]    w_handle,
  input  logic [LW-1:0]    w_idx,
  input  logic [WIDTH-1:0] w_data,
  input  logic [HW-1:0]    r_handle,
  input  logic [LW-1:0]    r_idx,
  output logic [WIDTH-1:0] r_data
);

  localparam int DEPTH = NUM_HANDLES * MAX_LEN;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  int               waddr;
  int               raddr;

  // Flat address is handle*MAX_LEN+index so MAX_LEN need not be a power of two.
  assign waddr = int'(w_handle) * MAX_LEN + int'(w_idx);
  assign raddr = int'(r_handle) * MAX_LEN + int'(r_idx);

  always_ff @(posedge clk) begin
    if (we && (waddr < DEPTH)) begin
      mem[AW'(waddr)] <= w_data;
    end
  end

  assign r_data = (raddr < DEPTH) ? mem[AW'(raddr)] : '0;

endmodule

// File: rtl/dyn_array_ctrl.sv
// Controller for a pool of dynamic arrays: serialises commands, zero-fills
// storage on NEW, keeps per-handle sizes and enforces bounds on element access.
module dyn_array_ctrl
  import dyn_array_pkg::*;
#(
  parameter  int WIDTH       = RSP_DATA_W,
  parameter  int NUM_HANDLES = 4,
  parameter  int MAX_LEN     = 16,
  localparam int HW          = (NUM_HANDLES > 1) ? $clog2(NUM_HANDLES) : 1,
  localparam int LW          = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [HW-1:0]    cmd_handle,
  input  logic [LW-1:0]    cmd_arg,
  input  logic [WIDTH-1:0] cmd_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic [LW-1:0]    rsp_size,
  output logic             rsp_err
);

  state_e           state_q, state_n;
  rsp_t             rsp_q, rsp_n;
  logic [LW-1:0]    size_q [NUM_HANDLES];
  logic [LW-1:0]    clr_cnt_q;
  logic [HW-1:0]    handle_p0;
  logic [LW-1:0]    arg_p0;

  logic             accept;
  logic [LW-1:0]    cur_size;
  logic             in_bounds;
  logic             size_we;
  logic [HW-1:0]    size_wh;
  logic [LW-1:0]    size_wval;
  logic             st_we;
  logic [HW-1:0]    st_handle;
  logic [LW-1:0]    st_idx;
  logic [WIDTH-1:0] st_wdata;
  logic [WIDTH-1:0] rd_data;

  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign cur_size  = size_q[cmd_handle];
  assign in_bounds = cmd_arg < cur_size;

  dyn_array_store #(
    .WIDTH       (WIDTH),
    .NUM_HANDLES (NUM_HANDLES),
    .MAX_LEN     (MAX_LEN),
    .HW          (HW),
    .LW          (LW)
  ) u_store (
    .clk      (clk),
    .we       (st_we),
    .w_handle (st_handle),
    .w_idx    (st_idx),
    .w_data   (st_wdata),
    .r_handle (cmd_handle),
    .r_idx    (cmd_arg),
    .r_data   (rd_data)
  );

  always_comb begin
    state_n   = state_q;
    rsp_n     = rsp_q;
    size_we   = 1'b0;
    size_wh   = cmd_handle;
    size_wval = '0;
    st_we     = 1'b0;
    st_handle = cmd_handle;
    st_idx    = cmd_arg;
    st_wdata  = cmd_wdata;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_n    = ST_RESP;
          rsp_n.data = '0;
          rsp_n.size = RSP_SIZE_W'(cur_size);
          rsp_n.err  = 1'b0;
          case (cmd_op)
            OP_NEW: begin
              if (cmd_arg == '0) begin
                size_we    = 1'b1;
                rsp_n.size = '0;
              end else if (cmd_arg > LW'(MAX_LEN)) begin
                rsp_n.err = 1'b1;
              end else begin
                state_n = ST_CLEAR;
              end
            end
            OP_DELETE: begin
              size_we    = 1'b1;
              rsp_n.size = '0;
            end
            OP_SIZE: ;
            OP_READ: begin
              if (in_bounds) rsp_n.data = RSP_DATA_W'(rd_data);
              else           rsp_n.err  = 1'b1;
            end
            OP_WRITE: begin
              if (in_bounds) st_we     = 1'b1;
              else           rsp_n.err = 1'b1;
            end
            default: rsp_n.err = 1'b1;
          endcase
        end
      end
      ST_CLEAR: begin
        st_we     = 1'b1;
        st_handle = handle_p0;
        st_idx    = clr_cnt_q;
        st_wdata  = '0;
        // Size becomes visible only once the last element has been zeroed.
        if (clr_cnt_q == arg_p0 - LW'(1)) begin
          state_n    = ST_RESP;
          size_we    = 1'b1;
          size_wh    = handle_p0;
          size_wval  = arg_p0;
          rsp_n.data = '0;
          rsp_n.size = RSP_SIZE_W'(arg_p0);
          rsp_n.err  = 1'b0;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rsp_q     <= '0;
      clr_cnt_q <= '0;
      for (int i = 0; i < NUM_HANDLES; i++) size_q[i] <= '0;
    end else begin
      state_q <= state_n;
      rsp_q   <= rsp_n;
      if (state_q == ST_CLEAR) clr_cnt_q <= clr_cnt_q + LW'(1);
      else                     clr_cnt_q <= '0;
      if (size_we) size_q[size_wh] <= size_wval;
    end
  end

  // p0: command capture for the multi-cycle NEW sequence
  always_ff @(posedge clk) begin
    if (accept) begin
      handle_p0 <= cmd_handle;
      arg_p0    <= cmd_arg;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = WIDTH'(rsp_q.data);
  assign rsp_size  = LW'(rsp_q.size);
  assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_dyn_array_ctrl.sv
// Directed bench for dyn_array_ctrl: expected responses are queued when each
// command is issued and compared when the response pulse appears.
module tb_dyn_array_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [1:0] cmd_handle = '0;
  logic [4:0] cmd_arg = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [4:0] rsp_size;
  logic       rsp_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic [4:0] size;
    logic       err;
    int         lat;
  } exp_t;

  exp_t sb[$];

  dyn_array_ctrl #(.WIDTH(8), .NUM_HANDLES(4), .MAX_LEN(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_handle (cmd_handle),
    .cmd_arg    (cmd_arg),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_size   (rsp_size),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Accept one command at a rising edge; returns once it has been taken.
  task automatic drive(input logic [2:0] op, input logic [1:0] h, input logic [4:0] arg,
                       input logic [7:0] wd);
    @(negedge clk);
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    if (!cmd_ready) chk("ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_handle = h;
    cmd_arg    = arg;
    cmd_wdata  = wd;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic cmd(input string tag, input logic [2:0] op, input logic [1:0] h,
                     input logic [4:0] arg, input logic [7:0] wd,
                     input logic [7:0] ed, input logic [4:0] es, input logic ee);
    exp_t e, got_e;
    int   lat, nready;
    bit   got;
    e.data = ed;
    e.size = es;
    e.err  = ee;
    e.lat  = (op == 3'd0 && arg != 0 && arg <= 16) ? int'(arg) + 1 : 1;
    sb.push_back(e);
    drive(op, h, arg, wd);
    lat = 0;
    nready = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (!cmd_ready) nready++;
      if (rsp_valid) got = 1'b1;
    end
    if (!got) begin
      chk({tag, "_timeout"}, 32'(got), 32'd1);
      void'(sb.pop_front());
    end else begin
      got_e = sb.pop_front();
      chk({tag, "_data"}, 32'(rsp_data), 32'(got_e.data));
      chk({tag, "_size"}, 32'(rsp_size), 32'(got_e.size));
      chk({tag, "_err"}, 32'(rsp_err), 32'(got_e.err));
      chk({tag, "_lat"}, 32'(lat), 32'(got_e.lat));
      chk({tag, "_busy"}, 32'(nready), 32'(got_e.lat));
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
    end
  endtask

  initial begin
    int pulses;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    chk("rst_size", 32'(rsp_size), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(cmd_ready), 32'd1);

    cmd("size_h0", 3'd2, 2'd0, 5'd0, 8'h00, 8'h00, 5'd0, 1'b0);
    cmd("read_h0_oob", 3'd3, 2'd0, 5'd0, 8'h00, 8'h00, 5'd0, 1'b1);

    cmd("new_h1_4", 3'd0, 2'd1, 5'd4, 8'h00, 8'h00, 5'd4, 1'b0);
    for (int k = 0; k < 4; k++)
      cmd($sformatf("read_h1_%0d", k), 3'd3, 2'd1, 5'(k), 8'h00, 8'h00, 5'd4, 1'b0);
    cmd("write_h1_2", 3'd4, 2'd1, 5'd2, 8'hA5, 8'h00, 5'd4, 1'b0);
    cmd("read_h1_2a5", 3'd3, 2'd1, 5'd2, 8'h00, 8'hA5, 5'd4, 1'b0);
    cmd("write_h1_oob", 3'd4, 2'd1, 5'd4, 8'h11, 8'h00, 5'd4, 1'b1);
    cmd("read_h1_oob", 3'd3, 2'd1, 5'd4, 8'h00, 8'h00, 5'd4, 1'b1);
    cmd("size_h0_again", 3'd2, 2'd0, 5'd0, 8'h00, 8'h00, 5'd0, 1'b0);

    cmd("new_h2_max", 3'd0, 2'd2, 5'd16, 8'h00, 8'h00, 5'd16, 1'b0);
    cmd("read_h2_15", 3'd3, 2'd2, 5'd15, 8'h00, 8'h00, 5'd16, 1'b0);
    cmd("new_h2_17", 3'd0, 2'd2, 5'd17, 8'h00, 8'h00, 5'd16, 1'b1);
    cmd("new_h2_31", 3'd0, 2'd2, 5'd31, 8'h00, 8'h00, 5'd16, 1'b1);
    cmd("delete_h2", 3'd1, 2'd2, 5'd0, 8'h00, 8'h00, 5'd0, 1'b0);
    cmd("new_h2_0", 3'd0, 2'd2, 5'd0, 8'h00, 8'h00, 5'd0, 1'b0);
    cmd("size_h1_kept", 3'd2, 2'd1, 5'd0, 8'h00, 8'h00, 5'd4, 1'b0);

    cmd("new_h3_2", 3'd0, 2'd3, 5'd2, 8'h00, 8'h00, 5'd2, 1'b0);
    cmd("write_h3_1", 3'd4, 2'd3, 5'd1, 8'h3C, 8'h00, 5'd2, 1'b0);
    cmd("read_h3_3c", 3'd3, 2'd3, 5'd1, 8'h00, 8'h3C, 5'd2, 1'b0);
    cmd("new_h3_3", 3'd0, 2'd3, 5'd3, 8'h00, 8'h00, 5'd3, 1'b0);
    cmd("read_h3_cleared", 3'd3, 2'd3, 5'd1, 8'h00, 8'h00, 5'd3, 1'b0);
    cmd("illegal_op6", 3'd6, 2'd3, 5'd0, 8'h00, 8'h00, 5'd3, 1'b1);
    cmd("read_h1_after", 3'd3, 2'd1, 5'd2, 8'h00, 8'hA5, 5'd4, 1'b0);

    drive(3'd0, 2'd0, 5'd8, 8'h00);
    repeat (3) @(negedge clk);
    chk("clear_busy", 32'(cmd_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(cmd_ready), 32'd0);
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_size", 32'(rsp_size), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    chk("midrst_no_rsp", 32'(pulses), 32'd0);
    chk("midrst_idle_ready", 32'(cmd_ready), 32'd1);
    cmd("size_h0_after_rst", 3'd2, 2'd0, 5'd0, 8'h00, 8'h00, 5'd0, 1'b0);
    cmd("size_h1_after_rst", 3'd2, 2'd1, 5'd0, 8'h00, 8'h00, 5'd0, 1'b0);
    cmd("read_h1_after_rst", 3'd3, 2'd1, 5'd2, 8'h00, 8'h00, 5'd0, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
